// File: rtl/logic_gate_accumulator.sv
// logic_gate_accumulator: folds DEPTH accepted (a op b) terms into one WIDTH-bit
// result using OR / AND / XOR / NOR, then holds it until the consumer takes it.
// The op is latched on the first sample of each reduction.
// Optional macro LOGIC_GATE_ACCUMULATOR_COUNT_EN adds the sample_count output.
module logic_gate_accumulator #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [1:0]                 op,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       clear,
    output logic [WIDTH-1:0]           x,
    output logic                       out_valid,
    input  logic                       out_ready
`ifdef LOGIC_GATE_ACCUMULATOR_COUNT_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] sample_count
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ACCUM = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OP_OR  = 2'b00,
        OP_AND = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] x_q, x_d;

    op_e              eff_op;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] merged;
    logic [CW-1:0]    count_inc;

    // Outputs come straight from registered state, so no path from in_valid/out_ready.
    assign in_ready  = (state_q != S_DONE);
    assign out_valid = (state_q == S_DONE);
    assign x         = x_q;
`ifdef LOGIC_GATE_ACCUMULATOR_COUNT_EN
    assign sample_count = count_q;
`endif

    // Per-sample term and its fold into the accumulator.
    always_comb begin
        eff_op = (state_q == S_IDLE) ? op_e'(op) : op_q;
        unique case (eff_op)
            OP_AND:  term = a & b;
            OP_XOR:  term = a ^ b;
            default: term = a | b;
        endcase
        if (state_q == S_IDLE) begin
            merged = term;
        end else begin
            unique case (eff_op)
                OP_AND:  merged = acc_q & term;
                OP_XOR:  merged = acc_q ^ term;
                default: merged = acc_q | term;
            endcase
        end
        count_inc = count_q + CW'(1);
    end

    // Next-state logic; clear overrides every other request.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        count_d = count_q;
        acc_d   = acc_q;
        x_d     = x_q;
        if (clear) begin
            state_d = S_IDLE;
            count_d = '0;
            acc_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_ACCUM: begin
                    if (in_valid) begin
                        count_d = count_inc;
                        acc_d   = merged;
                        op_d    = eff_op;
                        if (count_inc == DEPTH_C) begin
                            state_d = S_DONE;
                            x_d     = (eff_op == OP_NOR) ? ~merged : merged;
                        end else begin
                            state_d = S_ACCUM;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                        count_d = '0;
                        acc_d   = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    count_d = '0;
                    acc_d   = '0;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_OR;
            count_q <= '0;
            acc_q   <= '0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
        end
    end

endmodule

// File: tb/tb_logic_gate_accumulator.sv
// Directed bench for logic_gate_accumulator at WIDTH=8, DEPTH=4.
module tb_logic_gate_accumulator;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] op = 2'b00;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       clear = 1'b0;
    logic [7:0] x;
    logic       out_valid;
    logic       out_ready = 1'b0;
`ifdef LOGIC_GATE_ACCUMULATOR_COUNT_EN
    logic [2:0] sample_count;
`endif

    int unsigned tests = 0;
    int unsigned failed = 0;

    logic [7:0] va [4];

    logic_gate_accumulator #(.WIDTH(8), .DEPTH(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .op        (op),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .clear     (clear),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef LOGIC_GATE_ACCUMULATOR_COUNT_EN
        ,
        .sample_count (sample_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive four samples with fixed op and b, operands from va.
    task automatic run4(input logic [1:0] o, input logic [7:0] bb);
        for (int i = 0; i < 4; i++) begin
            op = o; a = va[i]; b = bb; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #12;
        chk("reset_x", {24'd0, x}, 32'h00);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        reset_n = 1'b1;
        step();

        // OR reduction, checking latency
        op = 2'b00; b = 8'h00; in_valid = 1'b1;
        a = 8'h01; step();
        a = 8'h02; step();
        a = 8'h04; step();
        chk("or_not_done_after3", {31'd0, out_valid}, 32'd0);
        chk("or_ready_after3", {31'd0, in_ready}, 32'd1);
        a = 8'h08; step();
        in_valid = 1'b0;
        chk("or_x", {24'd0, x}, 32'h0F);
        chk("or_out_valid", {31'd0, out_valid}, 32'd1);
        chk("or_in_ready", {31'd0, in_ready}, 32'd0);

        // Stall in DONE with in_valid noise: nothing moves
        in_valid = 1'b1; a = 8'hAA; op = 2'b10;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_x", {24'd0, x}, 32'h0F);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        drain();
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_in_ready", {31'd0, in_ready}, 32'd1);
        chk("idle_x_hold", {24'd0, x}, 32'h0F);

        // AND
        va[0] = 8'hFF; va[1] = 8'hF0; va[2] = 8'h3C; va[3] = 8'hFF;
        run4(2'b01, 8'hFF);
        chk("and_x", {24'd0, x}, 32'h30);
        chk("and_out_valid", {31'd0, out_valid}, 32'd1);
        drain();

        // XOR
        va[0] = 8'h01; va[1] = 8'h01; va[2] = 8'h01; va[3] = 8'h01;
        run4(2'b10, 8'h00);
        chk("xor_x", {24'd0, x}, 32'h00);
        chk("xor_out_valid", {31'd0, out_valid}, 32'd1);
        drain();

        // NOR
        run4(2'b11, 8'h02);
        chk("nor_x", {24'd0, x}, 32'hFC);
        drain();

        // op change after first sample is ignored
        op = 2'b00; a = 8'h01; b = 8'h00; in_valid = 1'b1; step();
        op = 2'b01;
        a = 8'h02; step();
        a = 8'h04; step();
        a = 8'h08; step();
        in_valid = 1'b0;
        chk("oplatch_x", {24'd0, x}, 32'h0F);
        drain();

        // clear after two accepts, with in_valid high
        op = 2'b00; b = 8'h00; in_valid = 1'b1;
        a = 8'h80; step();
        a = 8'h40; step();
`ifdef LOGIC_GATE_ACCUMULATOR_COUNT_EN
        chk("count_two", {29'd0, sample_count}, 32'd2);
`endif
        clear = 1'b1; a = 8'hFF; step();
        clear = 1'b0; in_valid = 1'b0;
        chk("clear_out_valid", {31'd0, out_valid}, 32'd0);
        chk("clear_in_ready", {31'd0, in_ready}, 32'd1);
        chk("clear_x_hold", {24'd0, x}, 32'h0F);
`ifdef LOGIC_GATE_ACCUMULATOR_COUNT_EN
        chk("clear_count", {29'd0, sample_count}, 32'd0);
`endif
        va[0] = 8'h01; va[1] = 8'h01; va[2] = 8'h02; va[3] = 8'h02;
        run4(2'b00, 8'h00);
        chk("post_clear_x", {24'd0, x}, 32'h03);
        chk("post_clear_out_valid", {31'd0, out_valid}, 32'd1);
`ifdef LOGIC_GATE_ACCUMULATOR_COUNT_EN
        chk("done_count", {29'd0, sample_count}, 32'd4);
`endif

        // clear beats out_ready in DONE
        clear = 1'b1; out_ready = 1'b1; step();
        clear = 1'b0; out_ready = 1'b0;
        chk("clear_done_out_valid", {31'd0, out_valid}, 32'd0);
        chk("clear_done_x_hold", {24'd0, x}, 32'h03);

        // async reset mid-ACCUM
        op = 2'b10; b = 8'h00; in_valid = 1'b1;
        a = 8'h11; step();
        a = 8'h22; step();
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_x", {24'd0, x}, 32'h00);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef LOGIC_GATE_ACCUMULATOR_COUNT_EN
        chk("rst_count", {29'd0, sample_count}, 32'd0);
`endif
        #1 reset_n = 1'b1;
        va[0] = 8'h0F; va[1] = 8'h01; va[2] = 8'h02; va[3] = 8'h04;
        run4(2'b10, 8'h00);
        chk("post_rst_x", {24'd0, x}, 32'h08);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/logic_gate_accumulator.md
LOGIC_GATE_ACCUMULATOR -- requirements
Module: logic_gate_accumulator

Interface
REQ-001 Parameter WIDTH, default 8: bit width of operands and result; SHALL be >= 1.
REQ-002 Parameter DEPTH, default 4: accepted samples per reduction; SHALL be >= 1.
REQ-003 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 op  input  2  operation: 00 OR, 01 AND, 10 XOR, 11 NOR.
REQ-006 a  input  WIDTH  first operand vector.
REQ-007 b  input  WIDTH  second operand vector.
REQ-008 in_valid  input  1  a/b/op valid this cycle.
REQ-009 in_ready  output  1  block accepts a sample this cycle.
REQ-010 clear  input  1  synchronous abort of the current reduction.
REQ-011 x  output  WIDTH  reduction result.
REQ-012 out_valid  output  1  x holds a completed result.
REQ-013 out_ready  input  1  consumer takes x this cycle.

Function
REQ-014 A sample SHALL be accepted on a rising edge where in_valid=1, in_ready=1 and clear=0.
REQ-015 Per-sample term t SHALL be bitwise a|b (OR, NOR), a&b (AND) or a^b (XOR).
REQ-016 The first accepted sample of a reduction SHALL load acc=t and latch op; each later sample SHALL set acc=acc|t, acc&t or acc^t per latched op (NOR uses OR).
REQ-017 op changes after the first sample of a reduction SHALL be ignored until the next reduction.
REQ-018 States: IDLE (count=0), ACCUM (0<count<DEPTH), DONE (result held).
REQ-019 IDLE->ACCUM on an accepted sample when DEPTH>1; IDLE->DONE on an accepted sample when DEPTH=1.
REQ-020 ACCUM->DONE on the edge accepting the DEPTH-th sample; count SHALL increment by one per accepted sample and never exceed DEPTH.
REQ-021 in_ready SHALL be 1 in IDLE and ACCUM and 0 in DONE.
REQ-022 On entering DONE, x SHALL load acc combined with the final term (inverted for NOR) and out_valid SHALL become 1 on the same edge; result latency = 1 cycle after the last accepting edge.
REQ-023 In DONE, x and out_valid SHALL stay stable while out_ready=0; on an edge with out_ready=1, the block SHALL go to IDLE and clear out_valid.
REQ-024 x SHALL keep its last value outside DONE.
REQ-025 clear=1 SHALL return the block to IDLE on that edge, discard acc/count, drop out_valid, and win over a simultaneous in_valid or out_ready.
REQ-026 No combinational path SHALL exist from in_valid or out_ready to in_ready or out_valid.

Reset
REQ-027 reset_n=0 SHALL immediately, independent of clock, force state IDLE, count 0, acc 0, x 0, out_valid 0, in_ready 1.
REQ-028 Assertion mid-reduction SHALL discard the partial result; the first edge after deassertion SHALL be able to accept a sample.

Configuration
REQ-029 Macro LOGIC_GATE_ACCUMULATOR_COUNT_EN: when defined, output port sample_count, width $clog2(DEPTH+1), SHALL show samples accepted in the current reduction (0 in IDLE, DEPTH in DONE); when undefined, the port SHALL be absent and behaviour otherwise identical.

Verification (WIDTH=8, DEPTH=4)
REQ-030 op=00, a=01,02,04,08, b=00 on four consecutive accepts -> x=0x0F, out_valid=1 one cycle after the fourth accept, in_ready=0.
REQ-031 op=01, a=FF,F0,3C,FF, b=FF -> x=0x30; op=10, a=01 four times, b=00 -> x=0x00; op=11, a=01, b=02 four times -> x=0xFC.
REQ-032 out_ready=0 for 5 cycles in DONE -> x and out_valid stable, in_ready=0; out_ready=1 -> IDLE next edge, out_valid=0, in_ready=1.
REQ-033 op switched from 00 to 01 after the first sample -> result computed as OR.
REQ-034 clear pulsed after 2 accepts with in_valid=1 in the same cycle -> sample not taken, count=0; next 4 samples give a result unaffected by the first 2.
REQ-035 reset_n low mid-ACCUM between edges -> x=0, out_valid=0, in_ready=1 without a clock edge; with COUNT_EN defined, sample_count=0.
